mmio_button_conditioner: RTL

// - Conditions raw devboard pushbuttons before they reach the JZJCoreF MMIO input port (mmioInputs[4][3:0]).
// - Per button: synchronises the input to the core clock, debounces it, and produces a clean level.
// - Also produces one-cycle press/release pulses and a sticky press latch that software clears.
// - Sits between the board pins and the top-level MMIO input wiring, in the same clock domain as the core.

---
 rtl/jzjcoref_io_pkg.sv | 23 ++
 rtl/mmio_button_conditioner_if.sv | 29 ++
 rtl/debounce_channel.sv | 128 ++++++++++++
 rtl/mmio_button_conditioner.sv | 45 ++++
 4 files changed

// File: rtl/jzjcoref_io_pkg.sv
// Shared types and defaults for the JZJCoreF board I/O conditioning blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jzjcoref_io_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } debounceState_t;

  localparam int NUM_BUTTONS_DEFAULT     = 4;
  localparam int SYNC_STAGES_DEFAULT     = 2;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;  // 10 ms at 50 MHz
  localparam bit ACTIVE_LOW_IN_DEFAULT   = 1'b1;

  // Debounced level is "down" once a press is accepted, until a release is accepted.
  function automatic logic is_down(debounceState_t s);
    return (s == PRESSED) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/mmio_button_conditioner_if.sv
// Button bundle between board pins / MMIO write strobes and the conditioner.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a free-running per-bit level or pulse.
interface mmio_button_conditioner_if
  import jzjcoref_io_pkg::*;
#(
  parameter int NUM_BUTTONS = NUM_BUTTONS_DEFAULT
);

  logic [NUM_BUTTONS-1:0] rawButton;
  logic [NUM_BUTTONS-1:0] clearLatched;
  logic [NUM_BUTTONS-1:0] buttonLevel;
  logic [NUM_BUTTONS-1:0] buttonPressed;
  logic [NUM_BUTTONS-1:0] buttonReleased;
  logic [NUM_BUTTONS-1:0] pressLatched;

  // Board/MMIO side: drives pins and clears, consumes conditioned outputs.
  modport master (
    output rawButton, clearLatched,
    input  buttonLevel, buttonPressed, buttonReleased, pressLatched
  );

  // Conditioner side.
  modport slave (
    input  rawButton, clearLatched,
    output buttonLevel, buttonPressed, buttonReleased, pressLatched
  );

endinterface

// File: rtl/debounce_channel.sv
// One button: synchroniser, debounce FSM/counter, press/release pulses, sticky press latch.
// Latency: clean pin edge to level_o = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles; latch 1 cycle after pulse.
// Backpressure: none; all outputs are registered free-running levels/pulses.
module debounce_channel
  import jzjcoref_io_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW_IN   = ACTIVE_LOW_IN_DEFAULT
) (
  input  logic clock,
  input  logic notReset,
  input  logic raw_i,
  input  logic clear_i,
  output logic level_o,
  output logic pressed_o,
  output logic released_o,
  output logic latched_o
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  debounceState_t         state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pressed_q, released_q;
  logic                   latched_q, latched_d;
  logic                   p;

  // Synchroniser chain; bit 0 takes the pin, MSB feeds the debouncer. Resets to "released".
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) sync_q <= {SYNC_STAGES{ACTIVE_LOW_IN}};
    else           sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  // Normalise polarity so p=1 always means "pin says pressed".
  assign p = ACTIVE_LOW_IN ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];

  // Debounce FSM: a change is accepted only after p holds for DEBOUNCE_CYCLES+1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (p) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!p) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (p) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Level follows the next state so it changes on the same edge the FSM accepts.
  assign level_d   = is_down(state_d);
  // Pulse is only ever 1 cycle, so "set wins" falls out of OR-ing it in.
  assign latched_d = pressed_q | (latched_q & ~clear_i);

  // FSM state and debounce counter.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered level and one-cycle edge pulses aligned with the first cycle of the new level.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      level_q    <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      pressed_q  <= level_d & ~level_q;
      released_q <= ~level_d & level_q;
    end
  end

  // Sticky press latch, cleared by software.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) latched_q <= 1'b0;
    else           latched_q <= latched_d;
  end

  assign level_o    = level_q;
  assign pressed_o  = pressed_q;
  assign released_o = released_q;
  assign latched_o  = latched_q;

endmodule

// File: rtl/mmio_button_conditioner.sv
// Conditions NUM_BUTTONS raw board buttons for the MMIO input port: one debounce channel per bit.
// Latency: clean pin edge to buttonLevel = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
// Backpressure: none; outputs are registered levels/pulses, inputs are sampled every cycle.
module mmio_button_conditioner
  import jzjcoref_io_pkg::*;
#(
  parameter int NUM_BUTTONS     = NUM_BUTTONS_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW_IN   = ACTIVE_LOW_IN_DEFAULT
) (
  input  logic                        clock,
  input  logic                        notReset,
  mmio_button_conditioner_if.slave    bus
);

  logic [NUM_BUTTONS-1:0] level_w;
  logic [NUM_BUTTONS-1:0] pressed_w;
  logic [NUM_BUTTONS-1:0] released_w;
  logic [NUM_BUTTONS-1:0] latched_w;

  // Channels are fully independent; no state is shared between bits.
  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW_IN   (ACTIVE_LOW_IN)
    ) u_chan (
      .clock      (clock),
      .notReset   (notReset),
      .raw_i      (bus.rawButton[gi]),
      .clear_i    (bus.clearLatched[gi]),
      .level_o    (level_w[gi]),
      .pressed_o  (pressed_w[gi]),
      .released_o (released_w[gi]),
      .latched_o  (latched_w[gi])
    );
  end

  assign bus.buttonLevel    = level_w;
  assign bus.buttonPressed  = pressed_w;
  assign bus.buttonReleased = released_w;
  assign bus.pressLatched   = latched_w;

endmodule
